// File: rtl/frame_scan_controller.sv
// Raster frame sequencer: walks row/col over one frame on a source/sink handshake,
// inserts optional per-line blanking, flags frame boundaries and counts finished frames.
module frame_scan_controller #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int HBLANK = 0,
  parameter int CW     = 13
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          continuous,
  input  logic          abort,
  input  logic          src_valid,
  input  logic          snk_ready,
  output logic          pix_en,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          sof,
  output logic          eol,
  output logic          eof,
  output logic          busy,
  output logic          done,
  output logic [15:0]   frame_cnt
);

  localparam int BW = (HBLANK < 2) ? 1 : $clog2(HBLANK);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(HEIGHT - 1);
  localparam logic [BW-1:0] HB_LAST  = BW'((HBLANK > 0) ? HBLANK - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_DONE
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] row_reg;
  logic [CW-1:0] col_reg;
  logic [BW-1:0] blank_reg;
  logic [15:0]   frame_cnt_reg;
  logic          done_reg;

  logic is_active;
  logic col_last;
  logic row_last;

  assign is_active = (state_reg == S_ACTIVE);
  assign col_last  = (col_reg == COL_LAST);
  assign row_last  = (row_reg == ROW_LAST);

  assign pix_en    = is_active & src_valid & snk_ready;
  assign row       = row_reg;
  assign col       = col_reg;
  assign sof       = is_active & (row_reg == '0) & (col_reg == '0);
  assign eol       = is_active & col_last;
  assign eof       = is_active & col_last & row_last;
  assign busy      = (state_reg != S_IDLE);
  assign done      = done_reg;
  assign frame_cnt = frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      row_reg       <= '0;
      col_reg       <= '0;
      blank_reg     <= '0;
      frame_cnt_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        // Abort discards the frame even if its last pixel transfers this cycle.
        state_reg <= S_IDLE;
        row_reg   <= '0;
        col_reg   <= '0;
        blank_reg <= '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start) begin
              state_reg <= S_ACTIVE;
              row_reg   <= '0;
              col_reg   <= '0;
            end
          end
          S_ACTIVE: begin
            if (pix_en) begin
              if (!col_last) begin
                col_reg <= col_reg + 1'b1;
              end else if (!row_last) begin
                col_reg <= '0;
                row_reg <= row_reg + 1'b1;
                if (HBLANK > 0) begin
                  state_reg <= S_HBLANK;
                  blank_reg <= '0;
                end
              end else begin
                col_reg       <= '0;
                row_reg       <= '0;
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
                done_reg      <= 1'b1;
                state_reg     <= S_DONE;
              end
            end
          end
          S_HBLANK: begin
            if (blank_reg == HB_LAST) begin
              state_reg <= S_ACTIVE;
              blank_reg <= '0;
            end else begin
              blank_reg <= blank_reg + 1'b1;
            end
          end
          S_DONE: begin
            state_reg <= continuous ? S_ACTIVE : S_IDLE;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_scan_controller.sv
// Bench: two controllers (HBLANK=2 and HBLANK=0) share one stimulus stream and are
// compared every cycle against an index/gap model of the frame scan.
module tb_frame_scan_controller;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = 13;

  logic clk = 1'b0;
  logic reset_n, start, continuous, abort, src_valid, snk_ready;

  logic          pe_a, sof_a, eol_a, eof_a, busy_a, done_a;
  logic [CW-1:0] row_a, col_a;
  logic [15:0]   fcnt_a;
  logic          pe_b, sof_b, eol_b, eof_b, busy_b, done_b;
  logic [CW-1:0] row_b, col_b;
  logic [15:0]   fcnt_b;

  always #5 clk = ~clk;

  frame_scan_controller #(.WIDTH(W), .HEIGHT(H), .HBLANK(2), .CW(CW)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous), .abort(abort),
    .src_valid(src_valid), .snk_ready(snk_ready), .pix_en(pe_a), .row(row_a), .col(col_a),
    .sof(sof_a), .eol(eol_a), .eof(eof_a), .busy(busy_a), .done(done_a), .frame_cnt(fcnt_a)
  );

  frame_scan_controller #(.WIDTH(W), .HEIGHT(H), .HBLANK(0), .CW(CW)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous), .abort(abort),
    .src_valid(src_valid), .snk_ready(snk_ready), .pix_en(pe_b), .row(row_b), .col(col_b),
    .sof(sof_b), .eol(eol_b), .eof(eof_b), .busy(busy_b), .done(done_b), .frame_cnt(fcnt_b)
  );

  // Model: a frame is a linear pixel index plus a countdown of blank cycles.
  typedef struct {
    bit          on;
    bit          in_done;
    int          idx;
    int          gap;
    logic [15:0] frames;
  } mdl_t;

  mdl_t ma, mb;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   chk_en   = 1'b0;
  int   cyc_n    = 0;

  function automatic logic [47:0] expect_out(mdl_t m, logic sv, logic sr);
    bit shown;
    int r, c;
    shown = m.on && !m.in_done && (m.gap == 0);
    r = m.idx / W;
    c = m.idx % W;
    return {shown && sv && sr, CW'(r), CW'(c), shown && (m.idx == 0), shown && (c == W - 1),
            shown && (m.idx == W * H - 1), m.on, m.in_done, m.frames};
  endfunction

  function automatic mdl_t step(mdl_t m, int hb, logic rn, logic ab, logic st, logic ct,
                                logic sv, logic sr);
    mdl_t n;
    n = m;
    if (!rn) begin
      n.on = 1'b0; n.in_done = 1'b0; n.idx = 0; n.gap = 0; n.frames = '0;
    end else if (ab) begin
      n.on = 1'b0; n.in_done = 1'b0; n.idx = 0; n.gap = 0;
    end else if (!m.on) begin
      if (st) begin n.on = 1'b1; n.idx = 0; end
    end else if (m.in_done) begin
      n.in_done = 1'b0; n.on = ct;
    end else if (m.gap > 0) begin
      n.gap = m.gap - 1;
    end else if (sv && sr) begin
      if (m.idx == W * H - 1) begin
        n.in_done = 1'b1; n.idx = 0; n.frames = m.frames + 16'd1;
      end else begin
        n.idx = m.idx + 1;
        if (n.idx % W == 0) n.gap = hb;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  always @(posedge clk) begin
    ma = step(ma, 2, reset_n, abort, start, continuous, src_valid, snk_ready);
    mb = step(mb, 0, reset_n, abort, start, continuous, src_valid, snk_ready);
    cyc_n++;
    chk_en = 1'b1;
  end

  // Monitor logs for literal checks
  int          a_rc[$];
  int          a_cyc[$];
  logic [2:0]  a_flags[$];
  int          a_done_n, a_done_cyc;
  int          b_pix_n, b_first, b_last, b_done_n, b_busy_gap;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_a", {pe_a, row_a, col_a, sof_a, eol_a, eof_a, busy_a, done_a, fcnt_a},
          expect_out(ma, src_valid, snk_ready));
      chk("cmp_b", {pe_b, row_b, col_b, sof_b, eol_b, eof_b, busy_b, done_b, fcnt_b},
          expect_out(mb, src_valid, snk_ready));
      if (pe_a) begin
        a_rc.push_back(int'(row_a) * 16 + int'(col_a));
        a_cyc.push_back(cyc_n);
        a_flags.push_back({sof_a, eol_a, eof_a});
      end
      if (done_a) begin a_done_n++; a_done_cyc = cyc_n; end
      if (pe_b) begin
        if (b_pix_n == 0) b_first = cyc_n;
        b_last = cyc_n;
        b_pix_n++;
      end
      if (done_b) b_done_n++;
      if (!busy_b && b_pix_n > 0 && b_pix_n < 36) b_busy_gap++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    a_rc.delete(); a_cyc.delete(); a_flags.delete();
    a_done_n = 0; a_done_cyc = 0;
    b_pix_n = 0; b_first = 0; b_last = 0; b_done_n = 0; b_busy_gap = 0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!busy_a && !busy_b) break;
      cyc();
    end
    chk(name, {busy_a, busy_b}, 2'b00);
  endtask

  task automatic check_order(input string name);
    bit ok;
    ok = (a_rc.size() == W * H);
    for (int i = 0; i < a_rc.size(); i++)
      if (a_rc[i] != (i / W) * 16 + (i % W)) ok = 1'b0;
    chk(name, ok, 1'b1);
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    clear_logs();
    reset_n = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    src_valid = 1'b0; snk_ready = 1'b0;
    repeat (3) cyc();
    chk("reset_a", {pe_a, row_a, col_a, sof_a, eol_a, eof_a, busy_a, done_a, fcnt_a}, 48'd0);
    chk("reset_b", {pe_b, row_b, col_b, sof_b, eol_b, eof_b, busy_b, done_b, fcnt_b}, 48'd0);
    reset_n = 1'b1;
    cyc();

    // Single frame, free-flowing
    src_valid = 1'b1; snk_ready = 1'b1;
    clear_logs();
    start = 1'b1; cyc(); start = 1'b0;
    wait_idle("t1_idle", 100);
    chk("t1_count", a_rc.size(), 12);
    chk("t1_first", a_rc[0], 0);
    chk("t1_last", a_rc[11], 2 * 16 + 3);
    chk("t1_gap0", a_cyc[4] - a_cyc[3], 3);
    chk("t1_gap1", a_cyc[8] - a_cyc[7], 3);
    chk("t1_done_lat", a_done_cyc - a_cyc[11], 1);
    chk("t1_flags_first", a_flags[0], 3'b100);
    chk("t1_flags_eol", {a_flags[3], a_flags[7], a_flags[11]}, 9'b010_010_011);
    chk("t1_fcnt", fcnt_a, 16'd1);
    check_order("t1_order");

    // Backpressure with a source stall
    clear_logs();
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      snk_ready = 1'($urandom_range(0, 1));
      src_valid = (i >= 6 && i < 11) ? 1'b0 : 1'b1;
      cyc();
      if (!busy_a && !busy_b) break;
    end
    src_valid = 1'b1; snk_ready = 1'b1;
    wait_idle("t2_idle", 50);
    check_order("t2_order");
    chk("t2_fcnt", fcnt_a, 16'd2);

    // Continuous: three frames on the unblanked instance
    clear_logs();
    continuous = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (b_done_n >= 2) break;
      cyc();
    end
    continuous = 1'b0;
    wait_idle("t3_idle", 200);
    chk("t3_pix", b_pix_n, 36);
    chk("t3_span", b_last - b_first, 37);
    chk("t3_busy_gap", b_busy_gap, 0);
    chk("t3_fcnt_b", fcnt_b, 16'd5);
    chk("t3_fcnt_a", fcnt_a, 16'd4);

    // Abort at (1,2), then restart
    clear_logs();
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (row_a == CW'(1) && col_a == CW'(2)) break;
      cyc();
    end
    chk("t4_reach", {row_a, col_a}, {CW'(1), CW'(2)});
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("t4_state", {busy_a, row_a, col_a, done_a}, '0);
    chk("t4_fcnt", fcnt_a, 16'd4);
    cyc();
    chk("t4_nodone", a_done_n, 0);
    clear_logs();
    start = 1'b1; cyc(); start = 1'b0;
    chk("t4_restart", {pe_a, row_a, col_a}, {1'b1, CW'(0), CW'(0)});
    wait_idle("t4_idle", 100);
    check_order("t4_order");
    chk("t4_fcnt2", fcnt_a, 16'd5);

    // start pulses while busy are ignored
    clear_logs();
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_a) break;
      start = (i % 3 == 1);
      cyc();
      start = 1'b0;
    end
    wait_idle("t5_idle", 50);
    check_order("t5_order");
    chk("t5_fcnt", fcnt_a, 16'd6);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      src_valid  = ($urandom_range(0, 3) != 0);
      snk_ready  = ($urandom_range(0, 3) != 0);
      start      = ($urandom_range(0, 7) == 0);
      abort      = ($urandom_range(0, 79) == 0);
      reset_n    = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 15) == 0) continuous = ~continuous;
      cyc();
    end
    start = 1'b0; abort = 1'b0; reset_n = 1'b1; continuous = 1'b0;
    src_valid = 1'b1; snk_ready = 1'b1;
    wait_idle("rand_idle", 200);

    // Reset mid-frame
    start = 1'b1; cyc(); start = 1'b0;
    repeat (5) cyc();
    chk("t6_midframe", busy_a, 1'b1);
    reset_n = 1'b0; cyc(); reset_n = 1'b1;
    chk("t6_reset_a", {pe_a, row_a, col_a, sof_a, eol_a, eof_a, busy_a, done_a, fcnt_a}, 48'd0);
    chk("t6_reset_b", {pe_b, row_b, col_b, sof_b, eol_b, eof_b, busy_b, done_b, fcnt_b}, 48'd0);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
